core_req_arbiter: RTL and testbench



---
 rtl/core_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_core_req_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_req_arbiter.sv
// Round-robin arbiter that serializes per-core 4-phase requests onto one shared memory port
// and returns data and Ack only on the granted core's lane. All other lanes are held at zero.
module core_req_arbiter #(
  parameter int NUM_CORES = 32,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CORES-1:0]        Core_Req,
  input  logic [NUM_CORES*ADDR_W-1:0] Core_Addr,
  output logic [NUM_CORES-1:0]        Core_Ack,
  output logic [NUM_CORES*DATA_W-1:0] Core_Data,
  output logic                        Mem_Req,
  output logic [ADDR_W-1:0]           Mem_Addr,
  input  logic                        Mem_Ack,
  input  logic [DATA_W-1:0]           Mem_Data,
  output logic [4:0]                  Grant_Id,
  output logic                        Timeout_Err
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   grant_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  cap_data_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               abort_q;
  logic               tmo_err_q;

  logic [PTR_W-1:0]   sel_idx;
  logic               sel_found;
  logic               grant_en;
  logic               capture_en;
  logic               timeout_hit;
  logic               tmo_expired;
  logic               granted_req;
  int                 idx;

  // NOTE: every variable driven in an always_comb gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!sel_found && Core_Req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  assign granted_req = Core_Req[grant_q];
  assign tmo_expired = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

  // A core that drops Req during the memory access forfeits its Ack; the access still drains.
  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    capture_en  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_en = 1'b1;
          state_d  = S_MEM;
        end
      end
      S_MEM: begin
        if (Mem_Ack) begin
          capture_en = 1'b1;
          state_d    = (abort_q || !granted_req) ? S_IDLE : S_RESP;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_d     = (abort_q || !granted_req) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (!granted_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      mem_addr_q <= '0;
      cap_data_q <= '0;
      tmo_cnt_q  <= '0;
      abort_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      tmo_err_q <= timeout_hit;
      if (grant_en) begin
        grant_q    <= sel_idx;
        mem_addr_q <= Core_Addr[int'(sel_idx)*ADDR_W +: ADDR_W];
        rr_ptr_q   <= (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
        tmo_cnt_q  <= '0;
        abort_q    <= 1'b0;
      end else if (state_q == S_MEM) begin
        if (!granted_req)          abort_q   <= 1'b1;
        if (tmo_cnt_q != TMO_MAX)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (capture_en)       cap_data_q <= Mem_Data;
      else if (timeout_hit) cap_data_q <= '0;
    end
  end

  assign Mem_Req     = (state_q == S_MEM);
  assign Mem_Addr    = mem_addr_q;
  assign Grant_Id    = 5'(grant_q);
  assign Timeout_Err = tmo_err_q;

  // Response lanes are decoded from the state so reset clears them without waiting for a clock.
  always_comb begin
    Core_Ack  = '0;
    Core_Data = '0;
    if (state_q == S_RESP) begin
      Core_Ack[grant_q]                           = 1'b1;
      Core_Data[int'(grant_q)*DATA_W +: DATA_W]   = cap_data_q;
    end
  end

  logic stray_data;
  always_comb begin
    stray_data = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!Core_Ack[i] && (Core_Data[i*DATA_W +: DATA_W] != '0)) stray_data = 1'b1;
    end
  end

  a_ack_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(Core_Ack));
  a_data_masked: assert property (@(posedge CLK) disable iff (RST) !stray_data);
  a_req_in_mem:  assert property (@(posedge CLK) disable iff (RST) Mem_Req |-> (state_q == S_MEM));

endmodule

// File: tb/tb_core_req_arbiter.sv
// Self-checking bench for core_req_arbiter: directed scenarios plus randomized request bursts
// checked against a transaction-level round-robin model.
module tb_core_req_arbiter;

  localparam int NC  = 32;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NC-1:0]      Core_Req;
  logic [NC*AW-1:0]   Core_Addr;
  logic [NC-1:0]      Core_Ack;
  logic [NC*DW-1:0]   Core_Data;
  logic               Mem_Req;
  logic [AW-1:0]      Mem_Addr;
  logic               Mem_Ack;
  logic [DW-1:0]      Mem_Data;
  logic [4:0]         Grant_Id;
  logic               Timeout_Err;

  core_req_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .Core_Req(Core_Req), .Core_Addr(Core_Addr),
    .Core_Ack(Core_Ack), .Core_Data(Core_Data),
    .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data),
    .Grant_Id(Grant_Id), .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side view of the cores and the arbitration model.
  logic [NC-1:0] req;
  logic [AW-1:0] addr [NC];
  int            m_ptr;
  int            m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [NC-1:0] reqv, input int ptr);
    for (int off = 0; off < NC; off++) begin
      if (reqv[(ptr + off) % NC]) return (ptr + off) % NC;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NC; i++) Core_Addr[i*AW +: AW] = addr[i];
    Core_Req = req;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req = '0; Mem_Ack = 1'b0; Mem_Data = '0;
    drive();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_ptr = 0; m_last = 0;
  endtask

  // Waits for the shared request; from IDLE it must appear after exactly one edge.
  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!Mem_Req && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check("mem_req_seen", Mem_Req, 1);
    check("req_to_mem_req_cycles", n, 1);
  endtask

  // One full transaction for whichever core the model says wins arbitration.
  task automatic run_txn(input int lat, input bit expect_tmo, input bit rerequest,
                         input logic [DW-1:0] rdata);
    int g;
    int waited;
    logic [DW-1:0]    d;
    logic [NC*DW-1:0] mask;
    g = rr_pick(req, m_ptr);
    wait_mem_req();
    check("grant_id", Grant_Id, g);
    check("mem_addr", Mem_Addr, addr[g]);
    m_ptr  = (g + 1) % NC;
    m_last = g;
    if (expect_tmo) begin
      Mem_Data = 32'hFFFF_FFFF;
      waited = 0;
      while (Mem_Req && waited < 40) begin
        @(negedge CLK);
        waited++;
      end
      check("tmo_mem_req_cycles", waited, TMO);
      check("tmo_err_pulse", Timeout_Err, 1);
      d = '0;
    end else begin
      repeat (lat) @(negedge CLK);
      check("mem_req_held", Mem_Req, 1);
      d = rdata;
      Mem_Ack = 1'b1; Mem_Data = d;
      @(negedge CLK);
      Mem_Ack = 1'b0; Mem_Data = $urandom;
      check("mem_req_dropped", Mem_Req, 0);
      check("tmo_err_quiet", Timeout_Err, 0);
    end
    mask = '0;
    mask[g*DW +: DW] = '1;
    check("core_ack", Core_Ack, 32'h1 << g);
    check("core_data_lane", Core_Data[g*DW +: DW], d);
    check("core_data_others_zero", |(Core_Data & ~mask), 0);
    req[g] = 1'b0;
    drive();
    @(negedge CLK);
    check("ack_clear", Core_Ack, 0);
    check("data_clear", |Core_Data, 0);
    if (expect_tmo) check("tmo_err_single", Timeout_Err, 0);
    if (rerequest) begin
      req[g] = 1'b1;
      drive();
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int g;
    logic ack_seen;
    for (int i = 0; i < NC; i++) addr[i] = '0;
    req = '0; Mem_Ack = 1'b0; Mem_Data = '0; RST = 1'b1;
    drive();

    // Reset state
    do_reset();
    check("rst_core_ack", Core_Ack, 0);
    check("rst_core_data", |Core_Data, 0);
    check("rst_mem_req", Mem_Req, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_grant_id", Grant_Id, 0);
    check("rst_timeout_err", Timeout_Err, 0);

    // Single request, 3-cycle memory
    addr[5] = 32'h0000_1000; req[5] = 1'b1; drive();
    run_txn(3, 0, 0, 32'hDEAD_BEEF);

    // Round-robin across 0, 3, 31 with zero-latency memory and immediate re-requests
    do_reset();
    addr[0] = 32'h0000_0A00; addr[3] = 32'h0000_0A03; addr[31] = 32'h0000_0A1F;
    req[0] = 1'b1; req[3] = 1'b1; req[31] = 1'b1; drive();
    for (int k = 0; k < 5; k++) run_txn(0, 0, (k < 4), 32'h5000_0000 + k);
    while (req != '0) run_txn(0, 0, 0, $urandom);

    // Timeout on core 2
    addr[2] = 32'h0000_2222; req[2] = 1'b1; drive();
    run_txn(0, 1, 0, '0);

    // Abort: core 7 withdraws during the memory access
    addr[7] = 32'h0700_0700; req[7] = 1'b1; drive();
    g = rr_pick(req, m_ptr);
    wait_mem_req();
    check("abort_grant_id", Grant_Id, g);
    m_ptr = (g + 1) % NC; m_last = g;
    @(negedge CLK);
    req[7] = 1'b0; drive();
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      ack_seen = ack_seen | (|Core_Ack);
    end
    check("abort_mem_held", Mem_Req, 1);
    Mem_Ack = 1'b1; Mem_Data = 32'hBAD0_0007;
    @(negedge CLK);
    Mem_Ack = 1'b0;
    check("abort_mem_req_dropped", Mem_Req, 0);
    repeat (4) begin
      ack_seen = ack_seen | (|Core_Ack);
      @(negedge CLK);
    end
    check("abort_no_ack", ack_seen, 0);
    addr[8] = 32'h0800_0800; req[8] = 1'b1; drive();
    run_txn(1, 0, 0, 32'h0808_0808);

    // Spurious Mem_Ack while idle
    Mem_Ack = 1'b1; Mem_Data = 32'h0000_1234;
    @(negedge CLK);
    Mem_Ack = 1'b0; Mem_Data = '0;
    @(negedge CLK);
    check("spurious_no_ack", Core_Ack, 0);
    check("spurious_no_mem_req", Mem_Req, 0);
    check("spurious_grant_kept", Grant_Id, m_last);
    addr[9] = 32'h0900_0900; req[9] = 1'b1; drive();
    run_txn(2, 0, 0, 32'hCAFE_0009);

    // Reset while core 4 holds Ack
    addr[4] = 32'h4444_0040; req[4] = 1'b1; drive();
    wait_mem_req();
    check("mid_rst_grant_id", Grant_Id, 4);
    Mem_Ack = 1'b1; Mem_Data = 32'h0404_0404;
    @(negedge CLK);
    Mem_Ack = 1'b0;
    check("mid_rst_pre_ack", Core_Ack, 32'h10);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_core_ack", Core_Ack, 0);
    check("mid_rst_core_data", |Core_Data, 0);
    check("mid_rst_mem_req", Mem_Req, 0);
    check("mid_rst_mem_addr", Mem_Addr, 0);
    check("mid_rst_grant_id", Grant_Id, 0);
    check("mid_rst_timeout_err", Timeout_Err, 0);
    @(negedge CLK);
    RST = 1'b0; req = '0; drive();
    m_ptr = 0; m_last = 0;
    Mem_Ack = 1'b1; Mem_Data = 32'h7777_7777;
    @(negedge CLK);
    Mem_Ack = 1'b0;
    @(negedge CLK);
    check("late_ack_no_core_ack", Core_Ack, 0);
    check("late_ack_no_mem_req", Mem_Req, 0);
    addr[1] = 32'h0100_0001; addr[30] = 32'h3000_001E;
    req[1] = 1'b1; req[30] = 1'b1; drive();
    run_txn(0, 0, 0, 32'h1111_0001);
    run_txn(1, 0, 0, 32'h3030_3030);

    // Randomized request bursts
    for (int r = 0; r < 20; r++) begin
      logic [NC-1:0] m;
      m = $urandom & $urandom;
      if (m == '0) m[r] = 1'b1;
      for (int i = 0; i < NC; i++) if (m[i]) addr[i] = $urandom;
      req = m; drive();
      while (req != '0) run_txn($urandom_range(0, 3), 0, 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
